// File: rtl/registro_serial_ctrl.sv
// Sequencer for the N-bit universal shift register: loads a word, shifts it out serially,
// reassembles the returned bitstream and flags any mismatch against the word sent.
module registro_serial_ctrl #(
   parameter int unsigned N          = 4,
   parameter logic [1:0]  MODO_LOAD  = 2'b10,
   parameter logic [1:0]  MODO_SHIFT = 2'b00
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         IN_VALID,
   output logic         IN_READY,
   input  logic [N-1:0] IN_DATA,
   input  logic         IN_DIR,
   input  logic         IN_FILL,
   input  logic         S_OUT,
   output logic [1:0]   MODO,
   output logic         DIR,
   output logic [N-1:0] D,
   output logic         S_IN,
   output logic         ENB,
   output logic         BUSY,
   output logic         OUT_VALID,
   output logic [N-1:0] OUT_DATA,
   output logic         ERR
);

   localparam int unsigned     CntW    = $clog2(N) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

   typedef enum logic [2:0] {StIdle, StLoad, StShift, StDrain, StDone} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [N-1:0]    word_q, word_d;
   logic [N-1:0]    asm_q, asm_d;
   logic [N-1:0]    out_q, out_d;
   logic            dir_q, dir_d;
   logic            fill_q, fill_d;
   logic [N-1:0]    asm_shifted;

   // Bits come back in the same order they left: MSB first when shifting left, LSB first otherwise.
   always_comb begin
      if (dir_q) begin
         asm_shifted = (asm_q << 1) | N'(S_OUT);
      end else begin
         asm_shifted = (asm_q >> 1) | (N'(S_OUT) << (N - 1));
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      dir_d   = dir_q;
      fill_d  = fill_q;
      asm_d   = asm_q;
      out_d   = out_q;
      case (state_q)
         StIdle: begin
            if (IN_VALID) begin
               word_d  = IN_DATA;
               dir_d   = IN_DIR;
               fill_d  = IN_FILL;
               asm_d   = '0;
               state_d = StLoad;
            end
         end
         StLoad: begin
            cnt_d   = '0;
            state_d = StShift;
         end
         StShift: begin
            // S_OUT is registered in the shift register, so it lags the first shift by one edge.
            if (cnt_q != '0) begin
               asm_d = asm_shifted;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            asm_d   = asm_shifted;
            out_d   = asm_shifted;
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         word_q  <= '0;
         dir_q   <= 1'b0;
         fill_q  <= 1'b0;
         asm_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         dir_q   <= dir_d;
         fill_q  <= fill_d;
         asm_q   <= asm_d;
         out_q   <= out_d;
      end
   end

   // Outputs decode registered state only, so register controls never see IN_* combinationally.
   always_comb begin
      IN_READY  = 1'b0;
      BUSY      = 1'b1;
      ENB       = 1'b0;
      MODO      = '0;
      D         = '0;
      DIR       = 1'b0;
      S_IN      = 1'b0;
      OUT_VALID = 1'b0;
      ERR       = 1'b0;
      case (state_q)
         StIdle: begin
            IN_READY = 1'b1;
            BUSY     = 1'b0;
         end
         StLoad: begin
            ENB  = 1'b1;
            MODO = MODO_LOAD;
            D    = word_q;
            DIR  = dir_q;
         end
         StShift: begin
            ENB  = 1'b1;
            MODO = MODO_SHIFT;
            D    = word_q;
            DIR  = dir_q;
            S_IN = fill_q;
         end
         StDone: begin
            OUT_VALID = 1'b1;
            ERR       = (out_q != word_q);
         end
         default: begin
         end
      endcase
   end

   assign OUT_DATA = out_q;

endmodule

// File: tb/tb_registro_serial_ctrl.sv
// Bench for registro_serial_ctrl: a behavioural shift register closes the loop, and a
// transaction-timeline model predicts every output each cycle.
module tb_registro_serial_ctrl;

   localparam int N = 4;

   logic         CLK = 1'b0;
   logic         RESET, IN_VALID, IN_READY, IN_DIR, IN_FILL, S_OUT;
   logic [N-1:0] IN_DATA, D, OUT_DATA;
   logic [1:0]   MODO;
   logic         DIR, S_IN, ENB, BUSY, OUT_VALID, ERR;

   int n_checks = 0;
   int n_pass   = 0;
   int n_pulses = 0;
   logic chk_en = 1'b0;
   logic stuck  = 1'b0;

   always #5 CLK = ~CLK;

   registro_serial_ctrl #(.N(N)) dut (
      .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
      .IN_DIR(IN_DIR), .IN_FILL(IN_FILL), .S_OUT(S_OUT), .MODO(MODO), .DIR(DIR), .D(D),
      .S_IN(S_IN), .ENB(ENB), .BUSY(BUSY), .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .ERR(ERR)
   );

   // Universal shift register the controller drives.
   logic [N-1:0] reg_q  = '0;
   logic         reg_so = 1'b0;
   always @(posedge CLK) begin
      if (ENB) begin
         if (MODO == 2'b10) begin
            reg_q <= D;
         end else if (MODO == 2'b00) begin
            if (DIR) begin
               reg_so <= reg_q[N-1];
               reg_q  <= {reg_q[N-2:0], S_IN};
            end else begin
               reg_so <= reg_q[0];
               reg_q  <= {S_IN, reg_q[N-1:1]};
            end
         end
      end
   end
   assign S_OUT = stuck ? 1'b0 : reg_so;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model: k = cycles since the accepting edge (0 = idle). Offsets 1 load, 2..N+1 shift,
   // N+2 drain, N+3 done.
   int           k = 0;
   logic [N-1:0] m_word = '0, m_last = '0;
   logic         m_dir = 1'b0, m_fill = 1'b0;
   always @(posedge CLK) begin
      if (RESET) begin
         k <= 0; m_word <= '0; m_last <= '0; m_dir <= 1'b0; m_fill <= 1'b0;
      end else if (k == 0) begin
         if (IN_VALID) begin
            k <= 1; m_word <= IN_DATA; m_dir <= IN_DIR; m_fill <= IN_FILL;
         end
      end else if (k == N + 3) begin
         k <= 0;
      end else begin
         k <= k + 1;
         if (k + 1 == N + 3) m_last <= stuck ? '0 : m_word;
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         logic e_enb, e_ov;
         e_enb = (k >= 1) && (k <= N + 1);
         e_ov  = (k == N + 3);
         chk("IN_READY", IN_READY, k == 0);
         chk("BUSY", BUSY, k != 0);
         chk("ENB", ENB, e_enb);
         chk("MODO", MODO, (k == 1) ? 2'b10 : 2'b00);
         chk("D", D, e_enb ? m_word : '0);
         chk("DIR", DIR, e_enb ? m_dir : 1'b0);
         chk("S_IN", S_IN, (k >= 2 && k <= N + 1) ? m_fill : 1'b0);
         chk("OUT_VALID", OUT_VALID, e_ov);
         chk("OUT_DATA", OUT_DATA, m_last);
         if (e_ov) chk("ERR", ERR, m_last != m_word);
         if (OUT_VALID) n_pulses++;
      end
   end

   task automatic send(input logic [N-1:0] w, input logic d, input logic f);
      int n = 0;
      while (!IN_READY && n < 40) begin
         @(posedge CLK); #1; n++;
      end
      chk("ready_wait", n < 40, 1);
      IN_DATA = w; IN_DIR = d; IN_FILL = f; IN_VALID = 1'b1;
      @(posedge CLK); #1 IN_VALID = 1'b0;
   endtask

   task automatic wait_done(output int lat, output logic [N-1:0] data, output logic err);
      lat = 0; data = '0; err = 1'b0;
      while (lat < 30) begin
         @(negedge CLK); lat++;
         if (OUT_VALID) begin
            data = OUT_DATA; err = ERR;
            break;
         end
      end
      chk("done_wait", lat < 30, 1);
   endtask

   int           lat, p, cnt_ov;
   int           t[2];
   logic [N-1:0] dv[2];
   logic [N-1:0] od;
   logic         oe;

   initial begin
      RESET = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; IN_DIR = 1'b0; IN_FILL = 1'b0;
      @(posedge CLK); #1 chk_en = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_ready", IN_READY, 1); chk("rst_enb", ENB, 0);
      chk("rst_busy", BUSY, 0); chk("rst_ov", OUT_VALID, 0);
      @(posedge CLK); #1 RESET = 1'b0;

      // Left shift, zero fill.
      send(4'b1011, 1'b1, 1'b0);
      chk("load_modo", MODO, 2'b10); chk("load_d", D, 4'b1011); chk("load_enb", ENB, 1);
      wait_done(lat, od, oe);
      chk("lat_left", lat, 7); chk("data_left", od, 4'b1011); chk("err_left", oe, 0);
      chk("q_left", reg_q, 4'b0000);

      // Right shift, one fill.
      send(4'b0110, 1'b0, 1'b1);
      wait_done(lat, od, oe);
      chk("data_right", od, 4'b0110); chk("err_right", oe, 0); chk("q_right", reg_q, 4'b1111);

      // Back-to-back with IN_VALID held.
      @(posedge CLK); #1;
      IN_DATA = 4'hA; IN_DIR = 1'b1; IN_FILL = 1'b0; IN_VALID = 1'b1;
      @(posedge CLK); #1 IN_DATA = 4'h5;
      p = 0;
      for (int i = 1; i <= 30 && p < 2; i++) begin
         @(negedge CLK);
         if (OUT_VALID) begin
            t[p] = i; dv[p] = OUT_DATA; p++;
         end
         if (p == 1 && IN_READY) begin
            @(posedge CLK); #1 IN_VALID = 1'b0;
         end
      end
      IN_VALID = 1'b0;
      chk("b2b_count", p, 2);
      chk("b2b_spacing", t[1] - t[0], 8);
      chk("b2b_first", dv[0], 4'hA); chk("b2b_second", dv[1], 4'h5);
      repeat (3) @(negedge CLK);
      chk("b2b_no_extra", BUSY, 0);

      // Stuck-at-0 serial return.
      @(posedge CLK); #1 stuck = 1'b1;
      send(4'hF, 1'b1, 1'b0);
      wait_done(lat, od, oe);
      chk("stuck_data", od, 4'b0000); chk("stuck_err", oe, 1);
      @(posedge CLK); #1 stuck = 1'b0;

      // Reset during the third shift cycle.
      send(4'h9, 1'b0, 1'b0);
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b1;
      @(posedge CLK); #1 RESET = 1'b0;
      chk("mid_rst_enb", ENB, 0); chk("mid_rst_ready", IN_READY, 1);
      cnt_ov = 0;
      repeat (12) begin
         @(negedge CLK);
         if (OUT_VALID) cnt_ov++;
      end
      chk("mid_rst_no_ov", cnt_ov, 0);
      send(4'h3, 1'b1, 1'b1);
      wait_done(lat, od, oe);
      chk("after_rst_data", od, 4'h3); chk("after_rst_err", oe, 0);

      // Randomized traffic, including stray resets and mid-transfer input churn.
      cnt_ov = n_pulses;
      for (int i = 0; i < 600; i++) begin
         @(posedge CLK); #1;
         RESET    = ($urandom_range(0, 59) == 0);
         IN_VALID = $urandom_range(0, 1) == 1;
         IN_DATA  = N'($urandom);
         IN_DIR   = $urandom_range(0, 1) == 1;
         IN_FILL  = $urandom_range(0, 1) == 1;
      end
      @(posedge CLK); #1 RESET = 1'b0; IN_VALID = 1'b0;
      repeat (20) @(posedge CLK);
      chk("random_pulses_seen", n_pulses > cnt_ov + 10, 1);

      @(negedge CLK);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/registro_serial_ctrl.md
Name: registro_serial_ctrl

Overview:
- Upstream sequencer for the N-bit universal shift register (`registro_cond` / `registro_struct` / yosys netlist).
- Accepts a parallel word over a VALID/READY handshake, drives MODO/D/DIR/ENB/S_IN to load the word, then shifts it out serially over N cycles.
- Reassembles the returned S_OUT bitstream into OUT_DATA and flags any mismatch against the word sent.
- Used as a closed-loop self-check stage in front of the register.

Parameters:
- N, 4, data width; must match the register width.
- MODO_LOAD, 2'b10, MODO code for parallel load (Q <= D).
- MODO_SHIFT, 2'b00, MODO code for shift with S_IN fill.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- IN_VALID  input  1  upstream word valid.
- IN_READY  output  1  block can accept a word; high only in IDLE.
- IN_DATA  input  N  word to serialize.
- IN_DIR  input  1  direction: 1 = left (MSB out first), 0 = right (LSB out first).
- IN_FILL  input  1  fill bit driven on S_IN during shifts.
- S_OUT  input  1  serial output returned from the register.
- MODO  output  2  register mode.
- DIR  output  1  register direction.
- D  output  N  register parallel input.
- S_IN  output  1  register serial input.
- ENB  output  1  register enable.
- BUSY  output  1  high in every state except IDLE.
- OUT_VALID  output  1  one-cycle pulse: OUT_DATA and ERR are valid.
- OUT_DATA  output  N  reassembled word.
- ERR  output  1  OUT_DATA != captured IN_DATA; qualified by OUT_VALID.

Behaviour:
- Register contract:
  - ENB=1 with MODO_LOAD loads Q <= D on the edge.
  - ENB=1 with MODO_SHIFT shifts one position per edge toward DIR, inserting S_IN.
  - S_OUT is registered and holds the bit shifted out on the most recent enabled shift edge.
- Reset (RESET=1 at an edge), from any state including mid-shift: state=IDLE; counter=0.
  - All outputs 0, except IN_READY=1.
  - Captured word, direction and fill cleared.
  - An in-flight word is dropped; no OUT_VALID.
- IDLE: IN_READY=1, ENB=0.
  - IN_VALID=1 at an edge captures IN_DATA, IN_DIR, IN_FILL into internal registers and goes to LOAD.
- LOAD, 1 cycle: ENB=1, MODO=MODO_LOAD, D=captured word, DIR=captured dir. Go to SHIFT, counter=0.
- SHIFT, N cycles: ENB=1, MODO=MODO_SHIFT, S_IN=captured fill, D=captured word (held stable).
  - On each edge with counter>=1, sample S_OUT into the assembly register. Counter increments.
  - At counter=N-1, go to DRAIN.
- DRAIN, 1 cycle: ENB=0 (register holds). Sample S_OUT (the Nth bit), then go to DONE.
- DONE, 1 cycle: OUT_VALID=1, OUT_DATA=assembly register, ERR=(assembly != captured word), BUSY=1. Go to IDLE.
  - OUT_DATA holds its value until the next DONE.
  - ERR is meaningful only when OUT_VALID=1.
- Assembly rule:
  - dir=1: bits arrive MSB first; shift the assembly register left, inserting at bit 0.
  - dir=0: bits arrive LSB first; shift right, inserting at bit N-1.
  - Either way, a fault-free register yields OUT_DATA == IN_DATA.
- Timing:
  - Handshake edge to OUT_VALID high = N+3 cycles.
  - Minimum word-to-word throughput = N+4 cycles (IN_READY returns in IDLE, the cycle after DONE).
- IN_VALID while BUSY is ignored; upstream must hold the word until it sees IN_READY.
- IN_DIR/IN_FILL changes during a transfer have no effect (captured values only).
- MODO, D, DIR, S_IN are 0 whenever ENB=0.
- ENB/MODO change only on clock edges (registered outputs); no combinational path from IN_* to register controls.
- Counter width is clog2(N)+1. For N=1, SHIFT lasts one cycle and DRAIN supplies the only sample.

Test Plan:
- Reset then idle → IN_READY=1, ENB=0, BUSY=0, OUT_VALID=0; a RESET pulse held 3 cycles keeps those values.
- IN_DATA=4'b1011, IN_DIR=1, IN_FILL=0 → LOAD on cycle 1 (MODO=10, D=1011), SHIFT cycles 2-5 (MODO=00, ENB=1), DRAIN cycle 6, then OUT_VALID at cycle 7 with OUT_DATA=1011, ERR=0; register Q=0000 after the shifts.
- IN_DATA=4'b0110, IN_DIR=0, IN_FILL=1 → OUT_DATA=0110, ERR=0; register Q=1111 after the transfer.
- Back-to-back words 4'hA then 4'h5 with IN_VALID held high → second word accepted at the first IDLE edge after DONE; two OUT_VALID pulses 8 cycles apart, data A then 5; IN_VALID during BUSY causes no extra capture.
- Force S_OUT stuck-at-0, send 4'hF → OUT_VALID with OUT_DATA=0000, ERR=1.
- Assert RESET during SHIFT counter=2 → next cycle IDLE, ENB=0, no OUT_VALID; a new word 4'h3 afterwards completes with OUT_DATA=3, ERR=0.
